data_mem_responder: RTL

Multi-cycle data-memory responder. It serves load/store requests from the pipeline's MEM stage, which is the initiator. The responder holds 16-bit big-endian word storage and answers each request after a fixed, parameterised latency. While a request is outstanding it raises stall so the pipeline freezes, and it signals completion with a one-cycle done pulse.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/mem_lat_counter.sv | 42 ++++
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state/op encodings and latency limits for the memory responders
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage request/response bundle for the data-memory responder
interface data_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  // The pipeline MEM stage initiates requests.
  modport master (
    output addr, data_in, rd, wr,
    input  data_out, done, stall, err
  );

  // The responder answers them.
  modport slave (
    input  addr, data_in, rd, wr,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - loadable down-counter with a zero-next flag for access latency
module mem_lat_counter
  import mem_resp_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_next_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; the counter never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  // One more decrement reaches zero, so the owner can leave its wait state now.
  assign zero_next_o = (count_q == W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency 16-bit data-memory responder; option MEM_ALIGN_CHECK_EN
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** MEM_WORDS_LOG2;
  localparam int AW    = MEM_WORDS_LOG2 + 1;

  if ((LATENCY < LATENCY_MIN) || (LATENCY > LATENCY_MAX)) begin : g_bad_latency
    $error("data_mem_responder: LATENCY out of range");
  end

  state_e state_q;
  state_e state_d;

  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  op_e           op_q;
  logic [15:0]   data_out_q;
  logic          err_q;

  // Words are big-endian: the high byte lives at the even byte address.
  logic [15:0]   mem_q [DEPTH] = '{default: '0};

  logic          req;
  logic          conflict;
  logic          accept;
  logic          commit;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_last;
  logic [CNT_W-1:0] unused_cnt;

  logic [AW-1:0] c_addr;
  logic [15:0]   c_data;
  op_e           c_op;
  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic          misalign;
  logic          unused_bits;

  assign req      = bus.rd ^ bus.wr;
  assign conflict = bus.rd & bus.wr;
  assign accept   = (state_q == IDLE) && req;

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (cnt_load),
    .load_val_i  (CNT_W'(LATENCY - 1)),
    .dec_i       (cnt_dec),
    .count_o     (unused_cnt),
    .zero_next_o (cnt_last)
  );

  // Next-state and counter control.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d  = BUSY;
            cnt_load = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Inputs still asserted here belong to the finished access.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The access commits on the edge that enters DONE. With LATENCY=1 that is the
  // accept edge itself, before the latches hold anything, so take the live bus.
  always_comb begin
    commit = (state_d == DONE) && (state_q != DONE);
    if (state_q == IDLE) begin
      c_addr = bus.addr[AW-1:0];
      c_data = bus.data_in;
      c_op   = bus.wr ? OP_WR : OP_RD;
    end else begin
      c_addr = addr_q;
      c_data = data_q;
      c_op   = op_q;
    end
    word_idx = c_addr[AW-1:1];
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign    = c_addr[0];
  assign unused_bits = ^bus.addr[15:AW];
`else
  // Odd byte addresses fall into the containing aligned word.
  assign misalign    = 1'b0;
  assign unused_bits = ^{bus.addr[15:AW], c_addr[0]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch so the access ignores input wiggle during BUSY.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= bus.addr[AW-1:0];
      data_q <= bus.data_in;
      op_q   <= bus.wr ? OP_WR : OP_RD;
    end
  end

  // Storage write; contents survive reset, and reset drops a pending store.
  always_ff @(posedge clk) begin
    if (!rst && commit && (c_op == OP_WR) && !misalign) begin
      mem_q[word_idx] <= c_data;
    end
  end

  // Load result register, held until the next successful load.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (commit && (c_op == OP_RD) && !misalign) begin
      data_out_q <= mem_q[word_idx];
    end
  end

  // Error pulse: rd/wr conflict shows the next cycle, misalignment in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ((state_q == IDLE) && conflict) || (commit && misalign);
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.done     = (state_q == DONE);
  assign bus.stall    = !rst && ((state_q == BUSY) || ((state_q == IDLE) && req));
  assign bus.err      = err_q;

endmodule
